bram_requester: RTL and testbench
=================================

// Module: bram_requester
// PURPOSE
//  Initiator-side controller for the single-port inferred bram. Accepts read/write requests
//  over a valid/ready channel and drives the bram's write/addr/data pins. Captures the bram's
//  one-cycle-latency read data. Returns read results over a valid/ready response channel.
//  A response FIFO with credit-based request throttling ensures a returned word is never dropped.
// PARAMETERS
//  memSize_p    8   bram address width (2**memSize_p words)
//  dataWidth_p  16  data word width
//  rspDepth_p   4   response FIFO depth; power of two, >=2; >=3 sustains 1 req/cycle
// PORTS
//  clk_i        in   1              clock, all state on rising edge
//  rst_ni       in   1              asynchronous active-low reset
//  req_valid_i  in   1              request present
//  req_ready_o  out  1              request accepted when valid&ready
//  req_write_i  in   1              1=write, 0=read
//  req_addr_i   in   memSize_p      word address
//  req_data_i   in   dataWidth_p    write data
//  rsp_valid_o  out  1              response word available
//  rsp_ready_i  in   1              consumer takes response when valid&ready
//  rsp_data_o   out  dataWidth_p    response data (FIFO head)
//  bram_write_o out  1              to bram write_i
//  bram_addr_o  out  memSize_p      to bram addr_i
//  bram_data_o  out  dataWidth_p    to bram data_i
//  bram_data_i  in   dataWidth_p    from bram data_o (registered in bram, 1-cycle latency)
// BEHAVIOUR
//  - Reset (async assert, sync release): FIFO empty, inflight=0, rsp_valid_o=0.
//    req_ready_o and bram_write_o are forced 0 while rst_ni=0.
//  - Reset mid-operation: in-flight read and all queued responses are discarded.
//    Nothing is emitted after release for pre-reset requests.
//  - accept = req_valid_i & req_ready_o. Addresses and data are not re-registered.
//    bram_addr_o=req_addr_i, bram_data_o=req_data_i, bram_write_o=accept&req_write_i.
//  - req_ready_o = rst_ni & (fifo_count + inflight < rspDepth_p).
//    Depends on registers only; no combinational path from rsp_ready_i.
//  - inflight <= accept & ~req_write_i, or accept (either direction) when WRITE_ACK_EN.
//    When inflight=1, bram_data_i is pushed into the FIFO that cycle.
//    bram_data_i is ignored when inflight=0 (the bram drives it every cycle).
//  - Read latency: accept at edge N. Data enters FIFO at edge N+1. rsp_valid_o=1 after edge N+1.
//  - FIFO: wrap-around read/write pointers (log2 rspDepth_p bits) plus count.
//    rsp_valid_o = count!=0; rsp_data_o = mem[rd_ptr].
//    Simultaneous push and pop: count unchanged, both pointers advance.
//    Pop when empty and push when full cannot occur (credit rule); assert under FORMAL.
//  - Ordering: responses are returned strictly in request-acceptance order.
//  - Writes: the bram is updated at the accept edge.
//    A read of the same address accepted on the next cycle returns the new data.
//  - Back-to-back accepts allowed every cycle while credit remains; rsp_ready_i=0 stalls
//    requests only once fifo_count+inflight reaches rspDepth_p.
// CONFIGURATION
//  WRITE_ACK_EN defined: each accepted write also produces a response.
//    The bram echoes written data on a write cycle, so rsp_data_o = the data written.
//    Credit accounting counts writes.
//  WRITE_ACK_EN undefined: writes produce no response and consume no credit beyond the accept cycle.
// TESTING
//  1 rst_ni=0 with req_valid_i=1 -> req_ready_o=0, bram_write_o=0, rsp_valid_o=0.
//    Release -> req_ready_o=1 next cycle.
//  2 write 0x12->0xBEEF, then read 0x12 next cycle -> rsp_valid_o=1 two edges after the read,
//    rsp_data_o=0xBEEF. Without WRITE_ACK_EN, exactly one response.
//  3 rsp_ready_i=0, reads issued every cycle to 0x00..0x07 -> exactly 4 accepts, then
//    req_ready_o=0. Set rsp_ready_i=1 -> data of 0x00..0x07 returned in order, no loss.
//  4 rspDepth_p=4, rsp_ready_i=1, continuous reads of 0x00..0x0F -> 16 accepts in 16 cycles,
//    16 in-order responses.
//  5 rst_ni pulsed low one cycle after a read accept, 2 responses queued -> rsp_valid_o=0
//    after release, no stale response ever appears.
//  6 WRITE_ACK_EN: write 0x05->0x1234 then read 0x05 -> responses 0x1234, 0x1234 in order.

Source files
------------

// File: rtl/bram_requester.sv
// bram_requester: initiator-side controller for a single-port, one-cycle-latency bram.
// Requests arrive on a valid/ready channel. Read results are buffered in a credit-protected
// response FIFO and returned in acceptance order.
// Optional feature macro: WRITE_ACK_EN (each accepted write also returns its data as a response).
module bram_requester #(
  parameter int unsigned memSize_p   = 8,
  parameter int unsigned dataWidth_p = 16,
  parameter int unsigned rspDepth_p  = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic                   req_write_i,
  input  logic [memSize_p-1:0]   req_addr_i,
  input  logic [dataWidth_p-1:0] req_data_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [dataWidth_p-1:0] rsp_data_o,
  output logic                   bram_write_o,
  output logic [memSize_p-1:0]   bram_addr_o,
  output logic [dataWidth_p-1:0] bram_data_o,
  input  logic [dataWidth_p-1:0] bram_data_i
);

  localparam int unsigned PtrW = (rspDepth_p > 1) ? $clog2(rspDepth_p) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned CrdW = CntW + 1;

  logic [dataWidth_p-1:0] fifo_mem [rspDepth_p];
  logic [PtrW-1:0]        wr_ptr;
  logic [PtrW-1:0]        rd_ptr;
  logic [CntW-1:0]        count;
  logic                   inflight;

  logic                   accept;
  logic                   inflight_d;
  logic                   push;
  logic                   pop;
  logic [CrdW-1:0]        credit_used;
  logic [CntW-1:0]        count_d;

  assign rsp_valid_o = (count != '0);
  assign rsp_data_o  = fifo_mem[rd_ptr];

  // Credit check, accept decode and bram pin drive; credit uses registered state only.
  always_comb begin
    credit_used  = CrdW'(count) + CrdW'(inflight);
    req_ready_o  = rst_ni & (credit_used < CrdW'(rspDepth_p));
    accept       = req_valid_i & req_ready_o;
    bram_write_o = accept & req_write_i;
    bram_addr_o  = req_addr_i;
    bram_data_o  = req_data_i;
`ifdef WRITE_ACK_EN
    inflight_d   = accept;
`else
    inflight_d   = accept & ~req_write_i;
`endif
    push         = inflight;
    pop          = rsp_valid_o & rsp_ready_i;
  end

  // Next FIFO occupancy; simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_d = count;
    unique case ({push, pop})
      2'b10:   count_d = count + CntW'(1);
      2'b01:   count_d = count - CntW'(1);
      default: count_d = count;
    endcase
  end

  // Control state: pointers, occupancy and the one-deep in-flight read marker.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= inflight_d;
      count    <= count_d;
      if (push) wr_ptr <= wr_ptr + PtrW'(1);
      if (pop)  rd_ptr <= rd_ptr + PtrW'(1);
    end
  end

  // Response storage; returned bram word lands here the cycle after the accept.
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr] <= bram_data_i;
  end

`ifdef FORMAL
  // Credit rule guarantees the FIFO never underflows or overflows.
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(pop && (count == '0)));
      assert (!(push && (count == CntW'(rspDepth_p))));
    end
  end
`endif

endmodule

// File: tb/tb_bram_requester.sv
// Scoreboard bench for bram_requester: bram behavioural model, directed scenarios, random traffic.
module tb_bram_requester;

  localparam int AW    = 8;
  localparam int DW    = 16;
  localparam int DEPTH = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          req_valid_i;
  logic          req_ready_o;
  logic          req_write_i;
  logic [AW-1:0] req_addr_i;
  logic [DW-1:0] req_data_i;
  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [DW-1:0] rsp_data_o;
  logic          bram_write_o;
  logic [AW-1:0] bram_addr_o;
  logic [DW-1:0] bram_data_o;
  logic [DW-1:0] bram_data_i;

  bram_requester #(.memSize_p(AW), .dataWidth_p(DW), .rspDepth_p(DEPTH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
    .req_addr_i(req_addr_i), .req_data_i(req_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
    .bram_write_o(bram_write_o), .bram_addr_o(bram_addr_o), .bram_data_o(bram_data_o),
    .bram_data_i(bram_data_i)
  );

  always #5 clk_i = ~clk_i;

  // Environment bram: registered read, written data echoed on a write cycle.
  logic [DW-1:0] bram_mem [2**AW];
  always @(posedge clk_i) begin
    if (bram_write_o) begin
      bram_mem[bram_addr_o] <= bram_data_o;
      bram_data_i           <= bram_data_o;
    end else begin
      bram_data_i <= bram_mem[bram_addr_o];
    end
  end

  // Reference: memory contents as seen by the request stream, plus expected response queue.
  logic [DW-1:0] ref_mem [2**AW];
  logic [DW-1:0] exp_q [$];
  int n_cmp = 0;
  int n_err = 0;
  int n_rsp = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: takes each response the consumer accepts and compares it with the queue head.
  always @(negedge clk_i) begin
    #1;
    if (rst_ni && rsp_valid_o && rsp_ready_i) begin
      if (exp_q.size() == 0) begin
        chk("spurious_rsp", 32'(rsp_valid_o), 32'(0));
      end else begin
        chk("rsp_data", 32'(rsp_data_o), 32'(exp_q.pop_front()));
        n_rsp++;
      end
    end
  end

  // One request cycle: inputs set after posedge, checked/recorded at negedge.
  task automatic drive(input logic v, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, output logic acc);
    logic exp_rdy;
    req_valid_i = v;
    req_write_i = w;
    req_addr_i  = a;
    req_data_i  = d;
    @(negedge clk_i);
    exp_rdy = rst_ni && (exp_q.size() < DEPTH);
    chk("req_ready", 32'(req_ready_o), 32'(exp_rdy));
    chk("bram_write", 32'(bram_write_o), 32'(v & req_ready_o & w));
    chk("bram_addr", 32'(bram_addr_o), 32'(a));
    acc = v & req_ready_o;
    if (acc) begin
      if (w) begin
        ref_mem[a] = d;
`ifdef WRITE_ACK_EN
        exp_q.push_back(d);
`endif
      end else begin
        exp_q.push_back(ref_mem[a]);
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic drain();
    int k;
    k = 0;
    req_valid_i = 1'b0;
    rsp_ready_i = 1'b1;
    while (exp_q.size() != 0 && k < 50) begin
      @(posedge clk_i);
      #1;
      k++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'(0));
    chk("drain_valid", 32'(rsp_valid_o), 32'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic acc;
    int   idx;
    int   r0;
    int   k;
    for (int i = 0; i < 2**AW; i++) begin
      bram_mem[i] = DW'($urandom);
      ref_mem[i]  = bram_mem[i];
    end

    // Reset with a pending write request: nothing may be accepted or written.
    rst_ni      = 1'b0;
    req_valid_i = 1'b1;
    req_write_i = 1'b1;
    req_addr_i  = 8'h33;
    req_data_i  = 16'hDEAD;
    rsp_ready_i = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_ready", 32'(req_ready_o), 32'(0));
    chk("rst_bram_write", 32'(bram_write_o), 32'(0));
    chk("rst_rsp_valid", 32'(rsp_valid_o), 32'(0));
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 16'h0, acc);

    // Write then read the same address: new data, observed one edge after the read accept.
    r0 = n_rsp;
    drive(1'b1, 1'b1, 8'h12, 16'hBEEF, acc);
    drive(1'b1, 1'b0, 8'h12, 16'h0000, acc);
    req_valid_i = 1'b0;
    @(negedge clk_i);
`ifndef WRITE_ACK_EN
    chk("lat_early", 32'(rsp_valid_o), 32'(0));
`endif
    @(posedge clk_i);
    @(negedge clk_i);
    chk("lat_valid", 32'(rsp_valid_o), 32'(1));
    chk("lat_data", 32'(rsp_data_o), 32'(16'hBEEF));
    @(posedge clk_i);
    #1;
    drain();
`ifdef WRITE_ACK_EN
    chk("wr_rd_count", 32'(n_rsp - r0), 32'(2));
`else
    chk("wr_rd_count", 32'(n_rsp - r0), 32'(1));
`endif

    // Stalled consumer: exactly DEPTH reads accepted, then all returned in order.
    rsp_ready_i = 1'b0;
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      drive(1'b1, 1'b0, AW'(idx), 16'h0, acc);
      if (acc) idx++;
    end
    chk("stall_accepts", 32'(idx), 32'(DEPTH));
    chk("stall_ready", 32'(req_ready_o), 32'(0));
    rsp_ready_i = 1'b1;
    k = 0;
    while (idx < 8 && k < 40) begin
      drive(1'b1, 1'b0, AW'(idx), 16'h0, acc);
      if (acc) idx++;
      k++;
    end
    chk("stall_all_issued", 32'(idx), 32'(8));
    drain();

    // Full throughput: one read per cycle with a ready consumer.
    r0 = n_rsp;
    idx = 0;
    for (int c = 0; c < 16; c++) begin
      drive(1'b1, 1'b0, AW'(idx), 16'h0, acc);
      if (acc) idx++;
    end
    chk("thru_accepts", 32'(idx), 32'(16));
    drain();
    chk("thru_rsps", 32'(n_rsp - r0), 32'(16));

    // Reset while two responses queued and one read in flight: all discarded.
    rsp_ready_i = 1'b0;
    for (int c = 0; c < 3; c++) drive(1'b1, 1'b0, AW'(8'h40 + c), 16'h0, acc);
    rst_ni = 1'b0;
    exp_q.delete();
    req_valid_i = 1'b1;
    req_write_i = 1'b1;
    @(negedge clk_i);
    chk("midrst_ready", 32'(req_ready_o), 32'(0));
    chk("midrst_bram_write", 32'(bram_write_o), 32'(0));
    chk("midrst_valid", 32'(rsp_valid_o), 32'(0));
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    rsp_ready_i = 1'b1;
    for (int c = 0; c < 6; c++) begin
      drive(1'b0, 1'b0, 8'h00, 16'h0, acc);
      chk("no_stale", 32'(rsp_valid_o), 32'(0));
    end

`ifdef WRITE_ACK_EN
    // Write acknowledgement followed by a read of the same word.
    r0 = n_rsp;
    drive(1'b1, 1'b1, 8'h05, 16'h1234, acc);
    drive(1'b1, 1'b0, 8'h05, 16'h0000, acc);
    drain();
    chk("ack_rsps", 32'(n_rsp - r0), 32'(2));
`endif

    // Random traffic on a small address window with a randomly stalling consumer.
    for (int c = 0; c < 400; c++) begin
      rsp_ready_i = ($urandom_range(0, 3) != 0);
      drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
            AW'($urandom_range(0, 15)), DW'($urandom), acc);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
